// File: rtl/sync_filter_edge.sv
// Multi-channel synchronizer: flop chain, stability filter, edge detect.
// Ports: clk, reset (sync, active-high), d[N] async in, q/rise/fall[N] out.
module sync_filter_edge #(
   parameter int           N         = 4,
   parameter int           STAGES    = 2,
   parameter int           FILTER    = 3,
   parameter logic [N-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] d,
   output logic [N-1:0] q,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall
);

   localparam int CW = $clog2(FILTER + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

   (* ASYNC_REG = "TRUE" *)
   logic [N-1:0] stage [STAGES];

   logic [CW-1:0] cnt [N];
   logic [N-1:0]  s;

   assign s = stage[STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            stage[k] <= RESET_VAL;
         end
         for (int i = 0; i < N; i++) begin
            cnt[i] <= '0;
         end
         q    <= RESET_VAL;
         rise <= '0;
         fall <= '0;
      end else begin
         // only stage[0] samples the asynchronous input
         stage[0] <= d;
         for (int k = 1; k < STAGES; k++) begin
            stage[k] <= stage[k-1];
         end
         for (int i = 0; i < N; i++) begin
            rise[i] <= 1'b0;
            fall[i] <= 1'b0;
            if (s[i] == q[i]) begin
               // any return to the held level restarts the count
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               q[i]    <= s[i];
               cnt[i]  <= '0;
               rise[i] <= s[i];
               fall[i] <= ~s[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

endmodule
